counter_ctrl: RTL and testbench
===============================

// Module: counter_ctrl
// PURPOSE
//  Sequencing controller for the 8-bit up-counter datapath. Accepts START/STOP/LOAD/CLEAR
//  commands over a valid/ready handshake and advances the count on prescaled ticks.
//  Detects the terminal count and runs in one-shot or periodic mode.
//  Reports status (busy, tc pulse, sticky flags) to the host/sequencer above it.
// PARAMETERS
//  WIDTH       8  count / terminal / load data width
//  PRESCALE_W  4  prescaler width; one tick every (prescale+1) clk cycles
// PORTS
//  clk        in   1           single clock, rising edge
//  reset      in   1           asynchronous, active-low reset
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           controller can accept a command this cycle
//  cmd_op     in   2           0=START 1=STOP 2=LOAD 3=CLEAR
//  cmd_data   in   WIDTH       LOAD value, ignored for other ops
//  terminal   in   WIDTH       terminal count, sampled on every tick
//  periodic   in   1           1=reload to 0 at terminal and keep running; 0=one-shot
//  prescale   in   PRESCALE_W  tick divider, sampled on every tick
//  count      out  WIDTH       current count (registered)
//  busy       out  1           state==RUN
//  tc_pulse   out  1           1-cycle pulse on the cycle after a terminal tick
//  tc_flag    out  1           sticky: terminal reached
//  overrun    out  1           sticky: terminal reached while tc_flag already set
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, count=0, prescaler=0, cmd_ready=1, all flags/pulses=0.
//  Handshake: a command is accepted when cmd_valid&cmd_ready at the clk edge.
//   cmd_ready drops to 0 for exactly the cycle after an accept, then returns to 1.
//   This limits the controller to one command per 2 cycles.
//  States: IDLE, RUN, PAUSE, DONE.
//   START: IDLE/PAUSE/DONE->RUN, prescaler=0; also clears tc_flag. In RUN it is a no-op.
//   STOP : RUN->PAUSE; count held; no-op in other states.
//   LOAD : count=cmd_data, prescaler=0, state unchanged.
//   CLEAR: count=0, prescaler=0, state=IDLE, tc_flag=overrun=0.
//  Tick: in RUN the prescaler counts 0..prescale. A tick occurs when prescaler==prescale;
//   the prescaler then returns to 0. With prescale=0 a tick occurs every cycle.
//  On a tick:
//   - count==terminal: tc_pulse=1 next cycle, tc_flag=1; overrun=1 if tc_flag already 1.
//     periodic=1: count=0, stay RUN.
//     periodic=0: count held, state=DONE.
//   - otherwise: count=count+1 mod 2^WIDTH. 255 wraps to 0 and continues to terminal;
//     this handles a LOAD above terminal.
//  Latency: START accepted at edge N, prescale=0 -> count increments at edge N+1.
//  Simultaneous events: an accepted command in the same cycle as a tick takes priority.
//   The tick is discarded and the prescaler restarts only if the op resets it.
//   STOP on a tick cycle: count is not incremented.
//  Reset mid-run: immediate return to reset values; no tc_pulse is emitted.
//  No states other than the four listed; an illegal encoding recovers to IDLE.
// STRUCTURE
//  counter_ctrl_pkg: state enum (IDLE/RUN/PAUSE/DONE), op codes (OP_START..OP_CLEAR),
//   default WIDTH/PRESCALE_W constants.
//  Sub-module counter_prescale: PRESCALE_W-bit divider.
//   Inputs: en, restart, prescale. Output: tick.
//  FSM, count register, incrementer and flag logic live in counter_ctrl.
// TESTING
//  1 Reset then START, prescale=0, terminal=5, periodic=0
//    -> count 1..5 on successive edges, tc_pulse once, state DONE, count holds 5.
//  2 periodic=1, terminal=3, prescale=2
//    -> count advances every 3 cycles: 0,1,2,3,0,...
//    -> tc_pulse every 12 cycles; second terminal sets overrun.
//  3 LOAD 250 with terminal=2, then START
//    -> count 251..255, 0, 1, 2, then tc_pulse; the 255->0 wrap is seen.
//  4 STOP issued on a tick cycle at count=7
//    -> count stays 7, busy=0.
//    -> START then resumes at 8 after prescale+1 cycles.
//  5 Back-to-back cmd_valid
//    -> cmd_ready 1,0,1,0; each second command waits one cycle; none lost or duplicated.
//  6 reset asserted mid-RUN at count=40
//    -> count=0, IDLE, flags 0 asynchronously (before next edge); no tc_pulse.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter sequencing controller.
// Holds the FSM state encoding, command op codes and default widths.
package counter_ctrl_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int PRESCALE_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  // Ops that force the tick divider back to phase 0 (START only when it leaves a non-RUN state).
  function automatic logic op_restarts_prescaler(input op_e op, input logic running);
    logic r;
    r = 1'b0;
    case (op)
      OP_START: r = !running;
      OP_LOAD:  r = 1'b1;
      OP_CLEAR: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/counter_prescale.sv
// Tick divider: while enabled, emits one tick every (prescale+1) clock cycles.
// restart forces the phase counter back to 0 and overrides the enable.
module counter_prescale #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PS_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == prescale);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + PS_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller for the up-counter: command handshake, RUN/PAUSE/DONE FSM,
// terminal-count detection (one-shot or periodic) and sticky status flags.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic [WIDTH-1:0]      terminal,
  input  logic                  periodic,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc_pulse,
  output logic                  tc_flag,
  output logic                  overrun
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic             pulse_q, pulse_d;
  logic             flag_q, flag_d;
  logic             ovr_q, ovr_d;

  logic             accept;
  logic             running;
  logic             restart;
  logic             tick;
  op_e              op;

  function automatic logic [WIDTH-1:0] count_inc(input logic [WIDTH-1:0] c);
    return c + CNT_ONE;
  endfunction

  assign op      = op_e'(cmd_op);
  assign accept  = cmd_valid && ready_q;
  assign running = (state_q == ST_RUN);
  assign restart = accept && op_restarts_prescaler(op, running);

  counter_prescale #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescale (
    .clk      (clk),
    .reset    (reset),
    .en       (running),
    .restart  (restart),
    .prescale (prescale),
    .tick     (tick)
  );

  // An accepted command owns the cycle; a coincident tick has no effect on count or flags.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ready_d = !accept;
    pulse_d = 1'b0;
    flag_d  = flag_q;
    ovr_d   = ovr_q;

    if (accept) begin
      case (op)
        OP_START: begin
          if (!running) begin
            state_d = ST_RUN;
            flag_d  = 1'b0;
          end
        end
        OP_STOP: begin
          if (running) begin
            state_d = ST_PAUSE;
          end
        end
        OP_LOAD: begin
          count_d = cmd_data;
        end
        OP_CLEAR: begin
          count_d = '0;
          state_d = ST_IDLE;
          flag_d  = 1'b0;
          ovr_d   = 1'b0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (tick) begin
      if (count_q == terminal) begin
        pulse_d = 1'b1;
        flag_d  = 1'b1;
        ovr_d   = ovr_q || flag_q;
        if (periodic) begin
          count_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        count_d = count_inc(count_q);
      end
    end

    case (state_q)
      ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ready_q <= 1'b1;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= ready_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cmd_ready = ready_q;
  assign count     = count_q;
  assign busy      = running;
  assign tc_pulse  = pulse_q;
  assign tc_flag   = flag_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed table, corner-case sequences and random traffic
// compared every cycle against a behavioural model of the controller.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] terminal;
  logic       periodic;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       busy;
  logic       tc_pulse;
  logic       tc_flag;
  logic       overrun;

  always #5 clk = ~clk;

  counter_ctrl #(
    .WIDTH      (8),
    .PRESCALE_W (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .terminal  (terminal),
    .periodic  (periodic),
    .prescale  (prescale),
    .count     (count),
    .busy      (busy),
    .tc_pulse  (tc_pulse),
    .tc_flag   (tc_flag),
    .overrun   (overrun)
  );

  int errors = 0;
  int checks = 0;

  localparam int MS_IDLE  = 0;
  localparam int MS_RUN   = 1;
  localparam int MS_PAUSE = 2;
  localparam int MS_DONE  = 3;

  // Behavioural model: state name, count value, cycles since last tick, handshake and flags.
  int m_state;
  int m_count;
  int m_phase;
  bit m_ready;
  bit m_pulse;
  bit m_flag;
  bit m_ovr;

  task automatic model_reset();
    m_state = MS_IDLE;
    m_count = 0;
    m_phase = 0;
    m_ready = 1'b1;
    m_pulse = 1'b0;
    m_flag  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    bit tk;
    int ns, nc, np;
    bit nf, no, npl;
    acc = cmd_valid && m_ready;
    tk  = (m_state == MS_RUN) && (m_phase == int'(prescale));
    ns  = m_state;
    nc  = m_count;
    nf  = m_flag;
    no  = m_ovr;
    npl = 1'b0;
    np  = m_phase;
    if (m_state == MS_RUN) np = tk ? 0 : (m_phase + 1) % 16;
    if (acc) begin
      if (cmd_op == 2'd0 && m_state != MS_RUN) begin
        ns = MS_RUN; np = 0; nf = 1'b0;
      end else if (cmd_op == 2'd1 && m_state == MS_RUN) begin
        ns = MS_PAUSE;
      end else if (cmd_op == 2'd2) begin
        nc = int'(cmd_data); np = 0;
      end else if (cmd_op == 2'd3) begin
        nc = 0; np = 0; ns = MS_IDLE; nf = 1'b0; no = 1'b0;
      end
    end else if (tk) begin
      if (m_count == int'(terminal)) begin
        npl = 1'b1;
        no  = m_ovr || m_flag;
        nf  = 1'b1;
        if (periodic) nc = 0;
        else ns = MS_DONE;
      end else begin
        nc = (m_count + 1) % 256;
      end
    end
    m_state = ns;
    m_count = nc;
    m_phase = np;
    m_ready = !acc;
    m_pulse = npl;
    m_flag  = nf;
    m_ovr   = no;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"},    int'(count),     m_count);
    chk({tag, ".ready"},    int'(cmd_ready), int'(m_ready));
    chk({tag, ".busy"},     int'(busy),      int'(m_state == MS_RUN));
    chk({tag, ".tc_pulse"}, int'(tc_pulse),  int'(m_pulse));
    chk({tag, ".tc_flag"},  int'(tc_flag),   int'(m_flag));
    chk({tag, ".overrun"},  int'(overrun),   int'(m_ovr));
  endtask

  // One clock: advance the model on the current inputs, then sample just after the edge.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] data, input string tag);
    int waited;
    waited = 0;
    while (!cmd_ready && waited < 4) begin
      step({tag, ".wait"});
      waited++;
    end
    chk({tag, ".ready_timeout"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step(tag);
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    bit       v;
    bit [1:0] op;
    int       exp_count;
    bit       exp_ready;
    bit       exp_busy;
    bit       exp_pulse;
    bit       exp_flag;
  } vec_t;

  vec_t vecs[8];
  int   wrap_exp[8];
  int   pulse_at[$];
  bit   ovr_first;
  int   idx;
  int   ncyc;
  bit   rdy_before;

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 8'd0;
    terminal  = 8'd5;
    periodic  = 1'b0;
    prescale  = 4'd0;
    model_reset();

    // START from reset, one-shot to terminal 5 with no prescaling.
    vecs[0] = '{1'b1, 2'd0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 3, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 4, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 5, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 2'd0, 5, 1'b1, 1'b0, 1'b0, 1'b1};

    wrap_exp[0] = 251; wrap_exp[1] = 252; wrap_exp[2] = 253; wrap_exp[3] = 254;
    wrap_exp[4] = 255; wrap_exp[5] = 0;   wrap_exp[6] = 1;   wrap_exp[7] = 2;

    #12;
    chk("reset.count", int'(count), 0);
    chk("reset.ready", int'(cmd_ready), 1);
    chk("reset.busy", int'(busy), 0);
    chk("reset.flags", int'({tc_pulse, tc_flag, overrun}), 0);
    reset = 1'b1;
    step("post_reset");

    for (int i = 0; i < 8; i++) begin
      cmd_valid = vecs[i].v;
      cmd_op    = vecs[i].op;
      step("t1");
      chk("t1.count", int'(count), vecs[i].exp_count);
      chk("t1.ready", int'(cmd_ready), int'(vecs[i].exp_ready));
      chk("t1.busy", int'(busy), int'(vecs[i].exp_busy));
      chk("t1.pulse", int'(tc_pulse), int'(vecs[i].exp_pulse));
      chk("t1.flag", int'(tc_flag), int'(vecs[i].exp_flag));
    end
    cmd_valid = 1'b0;

    // Periodic run: terminal 3, tick every 3 cycles, pulse every 12.
    send_cmd(2'd3, 8'd0, "t2.clear");
    terminal = 8'd3;
    periodic = 1'b1;
    prescale = 4'd2;
    send_cmd(2'd0, 8'd0, "t2.start");
    ovr_first = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step("t2");
      if (tc_pulse) begin
        pulse_at.push_back(c);
        if (pulse_at.size() == 1) ovr_first = overrun;
      end
    end
    chk("t2.npulses", pulse_at.size(), 2);
    if (pulse_at.size() >= 2) begin
      chk("t2.first_at", pulse_at[0], 12);
      chk("t2.spacing", pulse_at[1] - pulse_at[0], 12);
    end
    chk("t2.ovr_after_first", int'(ovr_first), 0);
    chk("t2.ovr_after_second", int'(overrun), 1);

    // LOAD above terminal: count must wrap through 255 -> 0 before reaching terminal.
    send_cmd(2'd3, 8'd0, "t3.clear");
    terminal = 8'd2;
    periodic = 1'b0;
    prescale = 4'd0;
    send_cmd(2'd2, 8'd250, "t3.load");
    chk("t3.loaded", int'(count), 250);
    send_cmd(2'd0, 8'd0, "t3.start");
    for (int i = 0; i < 8; i++) begin
      step("t3");
      chk("t3.seq", int'(count), wrap_exp[i]);
      chk("t3.no_early_pulse", int'(tc_pulse), 0);
    end
    step("t3");
    chk("t3.pulse", int'(tc_pulse), 1);
    chk("t3.done_busy", int'(busy), 0);
    chk("t3.hold", int'(count), 2);

    // STOP landing exactly on the tick that would move 7 -> 8.
    send_cmd(2'd3, 8'd0, "t4.clear");
    terminal = 8'd100;
    prescale = 4'd2;
    send_cmd(2'd2, 8'd6, "t4.load");
    send_cmd(2'd0, 8'd0, "t4.start");
    for (int i = 0; i < 5; i++) step("t4.run");
    chk("t4.at7", int'(count), 7);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    step("t4.stop");
    cmd_valid = 1'b0;
    chk("t4.stop_count", int'(count), 7);
    chk("t4.stop_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) step("t4.paused");
    chk("t4.paused_count", int'(count), 7);
    send_cmd(2'd0, 8'd0, "t4.restart");
    step("t4.resume");
    step("t4.resume");
    chk("t4.not_yet", int'(count), 7);
    step("t4.resume");
    chk("t4.resumed", int'(count), 8);

    // Back-to-back commands with cmd_valid held high.
    send_cmd(2'd3, 8'd0, "t5.clear");
    step("t5.idle");
    idx  = 0;
    ncyc = 0;
    cmd_valid = 1'b1;
    while (idx < 3 && ncyc < 10) begin
      cmd_op     = 2'd2;
      cmd_data   = 8'(10 * (idx + 1));
      rdy_before = cmd_ready;
      chk("t5.ready_pattern", int'(rdy_before), int'((ncyc % 2) == 0));
      step("t5");
      if (rdy_before) begin
        chk("t5.loaded", int'(count), 10 * (idx + 1));
        idx++;
      end
      ncyc++;
    end
    cmd_valid = 1'b0;
    chk("t5.accepted", idx, 3);
    chk("t5.cycles", ncyc, 5);
    step("t5.after");
    chk("t5.final", int'(count), 30);

    // Asynchronous reset in the middle of a run.
    send_cmd(2'd3, 8'd0, "t6.clear");
    terminal = 8'd200;
    prescale = 4'd0;
    periodic = 1'b0;
    send_cmd(2'd0, 8'd0, "t6.start");
    for (int i = 0; i < 40; i++) step("t6.run");
    chk("t6.at40", int'(count), 40);
    reset = 1'b0;
    model_reset();
    #2;
    chk("t6.async_count", int'(count), 0);
    chk("t6.async_busy", int'(busy), 0);
    chk("t6.async_ready", int'(cmd_ready), 1);
    chk("t6.async_flags", int'({tc_pulse, tc_flag, overrun}), 0);
    @(posedge clk);
    #1;
    check_model("t6.held");
    reset = 1'b1;
    step("t6.release");
    chk("t6.no_pulse", int'(tc_pulse), 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255))
                                              : 8'($urandom_range(0, 20));
      if ($urandom_range(0, 15) == 0) terminal = 8'($urandom_range(0, 20));
      if ($urandom_range(0, 31) == 0) periodic = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) prescale = 4'($urandom_range(0, 3));
      step("rand");
    end
    cmd_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
